// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter - shares one single-ported sync RAM between IF and MEM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  // data-access requester
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  // pipeline stall indications
  output logic              stall_if,
  output logic              stall_mem,
  // RAM side
  output logic              ram_ce,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic [3:0]          r_cnt;
  logic                r_collide;
  logic                r_ram_ce;
  logic                r_ram_we;
  logic [3:0]          r_ram_be;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [31:0]         r_ram_wdata;
  logic [31:0]         r_if_rdata;
  logic [31:0]         r_mem_rdata;
  logic                r_if_ready;
  logic                r_mem_ready;
  logic                w_grant_mem;
  logic                w_grant_if;
  logic                w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data requests have fixed priority; RESP never regrants so IF cannot starve
  // behind a single held data request.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_re || mem_we) begin
          w_grant_mem = 1'b1;
          w_state_nxt = BUSY;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_IF;
      r_cnt       <= 4'd0;
      r_collide   <= 1'b0;
      r_ram_ce    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_be    <= 4'd0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      if (w_grant_mem) begin
        r_owner     <= OWN_MEM;
        r_cnt       <= C_WAIT;
        r_collide   <= mem_re & mem_we;
        r_ram_ce    <= 1'b1;
        r_ram_we    <= mem_we;
        r_ram_be    <= mem_we ? mem_be : 4'b1111;
        r_ram_addr  <= mem_addr[ADDR_W+1:2];
        r_ram_wdata <= mem_wdata;
      end else if (w_grant_if) begin
        r_owner     <= OWN_IF;
        r_cnt       <= C_WAIT;
        r_collide   <= 1'b0;
        r_ram_ce    <= 1'b1;
        r_ram_we    <= 1'b0;
        r_ram_be    <= 4'b1111;
        r_ram_addr  <= if_addr[ADDR_W+1:2];
        r_ram_wdata <= 32'd0;
      end else if (r_state == BUSY) begin
        if (w_done) begin
          r_ram_ce <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_owner == OWN_IF) begin
            r_if_rdata <= ram_rdata;
            r_if_ready <= 1'b1;
          end else begin
            r_mem_ready <= 1'b1;
            // plain writes leave mem_rdata untouched; a re+we collision reads as zero
            if (!r_ram_we) begin
              r_mem_rdata <= ram_rdata;
            end else if (r_collide) begin
              r_mem_rdata <= 32'd0;
            end
          end
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign ram_ce    = r_ram_ce;
  assign ram_we    = r_ram_we;
  assign ram_be    = r_ram_be;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_ready  = r_if_ready;
  assign mem_ready = r_mem_ready;

  assign stall_if  = if_req & ~r_if_ready;
  assign stall_mem = (mem_re | mem_we) & ~r_mem_ready;

  // Byte-offset and above-range address bits are intentionally discarded.
  logic w_unused_lo;
  assign w_unused_lo = ^{if_addr[1:0], mem_addr[1:0]};

  generate
    if (ADDR_W < 30) begin : g_trunc_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{if_addr[31:ADDR_W+2], mem_addr[31:ADDR_W+2]};
    end
  endgenerate

endmodule

`default_nettype wire
